// File: rtl/fft_bin_energy_avg_pkg.sv
// Shared constants, bus payload type and width helpers for the FFT bin energy averager.
package fft_energy_pkg;

  localparam logic [7:0]  SR_AVG_ADDR    = 8'd1;
  localparam logic [7:0]  SR_THRESH_ADDR = 8'd2;
  localparam int unsigned XK_W           = 32;
  localparam int unsigned SQ_W           = 32;
  localparam int unsigned AVG_W          = 4;

  typedef struct packed {
    logic signed [XK_W/2-1:0] re;
    logic signed [XK_W/2-1:0] im;
  } xk_t;

  function automatic int unsigned acc_w(input int unsigned max_avg_log2);
    return SQ_W + max_avg_log2;
  endfunction

  function automatic int unsigned bin_w(input int unsigned fft_len);
    return (fft_len > 1) ? $clog2(fft_len) : 1;
  endfunction

endpackage

// File: rtl/fft_bin_energy_avg_bin_acc_ram.sv
// Per-bin accumulator storage: simple dual-port RAM with one-cycle registered read.
module bin_acc_ram #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned W     = 40,
  parameter int unsigned AW    = 10
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/fft_bin_energy_avg.sv
// Per-bin |X[k]|^2 averaged over 2^avg_log2 FFT frames, with threshold detect.
// Optional peak hold over each averaging period under FFT_ENERGY_PEAK_HOLD_EN.
module fft_bin_energy_avg
  import fft_energy_pkg::*;
#(
  parameter int unsigned FFT_LEN      = 1024,
  parameter int unsigned MAX_AVG_LOG2 = 8,
  parameter logic [7:0]  SR_AVG       = SR_AVG_ADDR,
  parameter logic [7:0]  SR_THRESH    = SR_THRESH_ADDR
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      set_stb,
  input  logic [7:0]                set_addr,
  input  logic [31:0]               set_data,
  input  logic [XK_W-1:0]           xk,
  input  logic                      dv_in,
  output logic [31:0]               energy,
  output logic [bin_w(FFT_LEN)-1:0] energy_bin,
  output logic                      dv_energy,
  output logic                      detect,
  output logic                      frame_done,
  output logic [31:0]               peak_energy,
  output logic [bin_w(FFT_LEN)-1:0] peak_bin
);

  localparam int unsigned      BIN_W    = bin_w(FFT_LEN);
  localparam int unsigned      ACC_W    = acc_w(MAX_AVG_LOG2);
  localparam int unsigned      FRM_W    = MAX_AVG_LOG2 + 1;
  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(FFT_LEN - 1);
  localparam logic [AVG_W-1:0] AVG_MAX  = AVG_W'(MAX_AVG_LOG2);

  xk_t                     xk_s;
  logic signed [SQ_W-1:0]  re2_c, im2_c;
  logic                    avg_wr_c, thr_wr_c;
  logic [AVG_W-1:0]        avg_log2;
  logic [31:0]             threshold;
  logic [BIN_W-1:0]        bin_cnt;
  logic [FRM_W-1:0]        frame_cnt, frame_max_c;

  logic                    s1_vld, s1_first, s1_last;
  logic [SQ_W-1:0]         s1_re2, s1_im2;
  logic [BIN_W-1:0]        s1_bin;
  logic [ACC_W-1:0]        ram_rd;
  logic [SQ_W-1:0]         sq_c;
  logic [ACC_W-1:0]        acc_c;

  logic                    s2_vld, s2_last;
  logic [ACC_W-1:0]        s2_acc, avg_c;
  logic [BIN_W-1:0]        s2_bin;
  logic [31:0]             energy_c;
  logic                    dv_energy_c;

  assign xk_s        = xk_t'(xk);
  assign re2_c       = SQ_W'(xk_s.re) * SQ_W'(xk_s.re);
  assign im2_c       = SQ_W'(xk_s.im) * SQ_W'(xk_s.im);
  assign avg_wr_c    = set_stb && (set_addr == SR_AVG);
  assign thr_wr_c    = set_stb && (set_addr == SR_THRESH);
  assign frame_max_c = (FRM_W'(1) << avg_log2) - FRM_W'(1);

  assign sq_c        = s1_re2 + s1_im2;
  assign acc_c       = s1_first ? ACC_W'(sq_c) : ram_rd + ACC_W'(sq_c);
  assign avg_c       = s2_acc >> avg_log2;
  assign energy_c    = 32'(avg_c);
  // An averaging-register write drops whatever is still in the pipe.
  assign dv_energy_c = s2_vld && s2_last && !avg_wr_c;

  // Settings registers and bin/frame position counters
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      avg_log2  <= '0;
      threshold <= '1;
      bin_cnt   <= '0;
      frame_cnt <= '0;
    end else begin
      if (thr_wr_c) threshold <= set_data;
      if (avg_wr_c) begin
        avg_log2  <= (set_data[AVG_W-1:0] > AVG_MAX) ? AVG_MAX : set_data[AVG_W-1:0];
        bin_cnt   <= '0;
        frame_cnt <= '0;
      end else if (dv_in) begin
        bin_cnt <= (bin_cnt == LAST_BIN) ? '0 : bin_cnt + BIN_W'(1);
        if (bin_cnt == LAST_BIN)
          frame_cnt <= (frame_cnt == frame_max_c) ? '0 : frame_cnt + FRM_W'(1);
      end
    end
  end

  // S1 squares / S2 accumulate
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld   <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_re2   <= '0;
      s1_im2   <= '0;
      s1_bin   <= '0;
      s2_vld   <= 1'b0;
      s2_last  <= 1'b0;
      s2_acc   <= '0;
      s2_bin   <= '0;
    end else begin
      s1_vld   <= dv_in && !avg_wr_c;
      s1_first <= (frame_cnt == '0);
      s1_last  <= (frame_cnt == frame_max_c);
      s1_re2   <= re2_c;
      s1_im2   <= im2_c;
      s1_bin   <= bin_cnt;
      s2_vld   <= s1_vld && !avg_wr_c;
      s2_last  <= s1_last;
      s2_acc   <= acc_c;
      s2_bin   <= s1_bin;
    end
  end

  bin_acc_ram #(
    .DEPTH (FFT_LEN),
    .W     (ACC_W),
    .AW    (BIN_W)
  ) u_ram (
    .clock (clock),
    .we    (s2_vld),
    .waddr (s2_bin),
    .wdata (s2_acc),
    .raddr (bin_cnt),
    .rdata (ram_rd)
  );

  // S3 averaged output and threshold compare
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dv_energy  <= 1'b0;
      frame_done <= 1'b0;
      energy     <= '0;
      energy_bin <= '0;
      detect     <= 1'b0;
    end else begin
      dv_energy  <= dv_energy_c;
      frame_done <= dv_energy_c && (s2_bin == LAST_BIN);
      if (dv_energy_c) begin
        energy     <= energy_c;
        energy_bin <= s2_bin;
        detect     <= energy_c > threshold;
      end
    end
  end

`ifdef FFT_ENERGY_PEAK_HOLD_EN
  logic [31:0]      run_max;
  logic [BIN_W-1:0] run_bin;

  // Running max restarts at bin 0; strict compare keeps the lowest bin on ties
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      run_max     <= '0;
      run_bin     <= '0;
      peak_energy <= '0;
      peak_bin    <= '0;
    end else begin
      if (dv_energy_c && ((s2_bin == '0) || (energy_c > run_max))) begin
        run_max <= energy_c;
        run_bin <= s2_bin;
      end
      if (frame_done) begin
        peak_energy <= run_max;
        peak_bin    <= run_bin;
      end
    end
  end
`else
  assign peak_energy = '0;
  assign peak_bin    = '0;
`endif

endmodule

// File: tb/tb_fft_bin_energy_avg.sv
// Randomized bench for fft_bin_energy_avg against a bin/frame-level reference model.
module tb_fft_bin_energy_avg;

  localparam int unsigned LEN   = 64;
  localparam int unsigned BW    = 6;
  localparam logic [7:0]  A_AVG = 8'd1;
  localparam logic [7:0]  A_THR = 8'd2;

  logic          clock    = 1'b0;
  logic          reset_n  = 1'b0;
  logic          set_stb  = 1'b0;
  logic [7:0]    set_addr = '0;
  logic [31:0]   set_data = '0;
  logic [31:0]   xk       = '0;
  logic          dv_in    = 1'b0;
  logic [31:0]   energy;
  logic [BW-1:0] energy_bin;
  logic          dv_energy;
  logic          detect;
  logic          frame_done;
  logic [31:0]   peak_energy;
  logic [BW-1:0] peak_bin;

  fft_bin_energy_avg #(
    .FFT_LEN      (LEN),
    .MAX_AVG_LOG2 (8)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .set_stb     (set_stb),
    .set_addr    (set_addr),
    .set_data    (set_data),
    .xk          (xk),
    .dv_in       (dv_in),
    .energy      (energy),
    .energy_bin  (energy_bin),
    .dv_energy   (dv_energy),
    .detect      (detect),
    .frame_done  (frame_done),
    .peak_energy (peak_energy),
    .peak_bin    (peak_bin)
  );

  always #5 clock = ~clock;

  typedef struct {
    int              due;
    int unsigned     bin;
    longint unsigned e;
    bit              fdone;
  } exp_t;

  exp_t            pend[$];
  longint unsigned sum_m [LEN];
  int unsigned     m_bin, m_frame, m_avg;
  longint unsigned m_thr;
  longint unsigned run_e, pk_e;
  int unsigned     run_b, pk_b;
  int              pk_due;
  int              cyc, checks, errors;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    m_bin  = 0;
    m_frame = 0;
    m_avg  = 0;
    m_thr  = 64'hFFFF_FFFF;
    run_e  = 0;
    run_b  = 0;
    pk_e   = 0;
    pk_b   = 0;
    pk_due = -1;
  endtask

  // Called just after the clock edge with the inputs that edge sampled
  task automatic model_edge(input logic dv, input logic [31:0] x, input logic stb,
                            input logic [7:0] a, input logic [31:0] d);
    exp_t              e;
    logic signed [15:0] r, i;
    longint            sq;
    bit                avg_wr;
    avg_wr = stb && (a == A_AVG);
    if (avg_wr) begin
      pend.delete();
      m_bin   = 0;
      m_frame = 0;
      m_avg   = (d[3:0] > 4'd8) ? 8 : int'(d[3:0]);
    end
    if (cyc == pk_due) begin
      pk_e = run_e;
      pk_b = run_b;
    end
    if (pend.size() > 0 && pend[0].due == cyc) begin
      e = pend.pop_front();
      check("dv_energy", dv_energy, 1);
      check("energy", energy, e.e);
      check("energy_bin", energy_bin, e.bin);
      check("detect", detect, e.e > m_thr);
      check("frame_done", frame_done, e.fdone);
      if (e.bin == 0 || e.e > run_e) begin
        run_e = e.e;
        run_b = e.bin;
      end
      if (e.fdone) pk_due = cyc + 1;
    end else begin
      check("dv_idle", dv_energy, 0);
      check("frame_done_idle", frame_done, 0);
    end
`ifdef FFT_ENERGY_PEAK_HOLD_EN
    check("peak_energy", peak_energy, pk_e);
    check("peak_bin", peak_bin, pk_b);
`else
    check("peak_energy_tied", peak_energy, 0);
    check("peak_bin_tied", peak_bin, 0);
`endif
    if (stb && a == A_THR) m_thr = d;
    if (dv && !avg_wr) begin
      r  = x[31:16];
      i  = x[15:0];
      sq = longint'(r) * longint'(r) + longint'(i) * longint'(i);
      sum_m[m_bin] = (m_frame == 0) ? longint'(sq) : sum_m[m_bin] + sq;
      if (m_frame == (1 << m_avg) - 1) begin
        e.due   = cyc + 2;
        e.bin   = m_bin;
        e.e     = sum_m[m_bin] >> m_avg;
        e.fdone = (m_bin == LEN - 1);
        pend.push_back(e);
      end
      m_bin++;
      if (m_bin == LEN) begin
        m_bin = 0;
        m_frame++;
        if (m_frame == (1 << m_avg)) m_frame = 0;
      end
    end
  endtask

  task automatic step(input logic dv, input logic [31:0] x, input logic stb,
                      input logic [7:0] a, input logic [31:0] d);
    @(negedge clock);
    dv_in    = dv;
    xk       = x;
    set_stb  = stb;
    set_addr = a;
    set_data = d;
    @(posedge clock);
    cyc++;
    #1;
    model_edge(dv, x, stb, a, d);
  endtask

  task automatic feed(input logic [31:0] x);
    step(1'b1, x, 1'b0, 8'd0, 32'd0);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    step(1'b0, 32'd0, 1'b1, a, d);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 32'd0, 1'b0, 8'd0, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    dv_in   = 1'b0;
    set_stb = 1'b0;
    #1;
    check("rst_dv_energy", dv_energy, 0);
    check("rst_energy", energy, 0);
    check("rst_energy_bin", energy_bin, 0);
    check("rst_detect", detect, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_peak_energy", peak_energy, 0);
    check("rst_peak_bin", peak_bin, 0);
    model_reset();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    model_reset();
    do_reset();

    // No averaging, 3+4j on every bin, default threshold
    for (int k = 0; k < int'(LEN); k++) feed(32'h0003_0004);
    idle(5);

    // Four-frame average of a ramp, with random gaps
    wr(A_AVG, 32'd2);
    for (int f = 0; f < 4; f++)
      for (int k = 0; k < int'(LEN); k++) begin
        if ($urandom_range(3) == 0) idle(1);
        feed({16'(k), 16'h0000});
      end
    idle(5);

    // Full-scale negative on both rails
    wr(A_AVG, 32'd0);
    for (int k = 0; k < int'(LEN); k++) feed(32'h8000_8000);
    idle(5);

    // Threshold boundary and a mid-frame threshold change
    wr(A_THR, 32'd100);
    wr(A_AVG, 32'd0);
    feed({16'd10, 16'd0});
    feed({16'd10, 16'd1});
    feed({16'd10, 16'd0});
    step(1'b1, {16'd10, 16'd0}, 1'b1, A_THR, 32'd99);
    feed({16'd10, 16'd0});
    for (int k = 5; k < int'(LEN); k++) feed({16'($urandom_range(12)), 16'($urandom_range(12))});
    idle(5);

    // Averaging change while output bins are in flight
    for (int k = 0; k < 20; k++) feed($urandom);
    step(1'b1, $urandom, 1'b1, A_AVG, 32'd1);

    // Random traffic, threshold churn, another averaging change mid-frame
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(19) == 0) wr(A_THR, $urandom);
      else if ($urandom_range(3) != 0) feed($urandom);
      else idle(1);
    end
    step(1'b1, $urandom, 1'b1, A_AVG, 32'd3);
    for (int n = 0; n < 700; n++) begin
      if ($urandom_range(29) == 0) wr(A_THR, $urandom);
      else if ($urandom_range(3) != 0) feed($urandom);
      else idle(1);
    end
    idle(5);

    // Single strong bin for peak hold
    wr(A_AVG, 32'd0);
    for (int k = 0; k < int'(LEN); k++) feed((k == 37) ? {16'd1000, 16'd0} : 32'd0);
    idle(5);
`ifdef FFT_ENERGY_PEAK_HOLD_EN
    check("peak37_bin", peak_bin, 37);
    check("peak37_energy", peak_energy, 1_000_000);
`endif

    // Async reset mid-frame, then a clean frame from bin 0
    for (int k = 0; k < 10; k++) feed($urandom);
    do_reset();
    for (int k = 0; k < int'(LEN); k++) feed($urandom);
    idle(5);

    check("pending_drained", pend.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
